// File: rtl/piso_fifo_ser.sv
// piso_fifo_ser: FIFO-buffered parallel-in/serial-out transmitter on a two-wire scl/sda link
// Each word is framed by a start (sda falls, scl high) and a stop (sda rises, scl high).
module piso_fifo_ser #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1,
   parameter int CLK_DIV   = 2
) (
   input  logic                       sclk,
   input  logic                       rst,
   input  logic                       d_en,
   input  logic [WIDTH-1:0]           data,
   output logic                       d_rdy,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       scl,
   output logic                       sda,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int IW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, START, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [LW-1:0]    count_q, count_d;
   logic             scl_q, scl_d, sda_q, sda_d, busy_q, busy_d;
   logic             done_q, done_d, ovf_q, ovf_d, rdy_q, rdy_d;
   logic             full, push, pop, last_phase;

   assign full       = count_q == LW'(DEPTH);
   assign push       = d_en & ~full;
   assign pop        = (state_q == IDLE) && (count_q != '0);
   assign last_phase = phase_q == PW'(CLK_DIV-1);

   always_comb begin
      state_d = state_q;
      phase_d = (last_phase || state_q == IDLE) ? '0 : phase_q + PW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_q];
         end
         START: if (last_phase) begin
            state_d = BIT_LOW;
            idx_d   = '0;
         end
         BIT_LOW: if (last_phase) state_d = BIT_HIGH;
         BIT_HIGH: if (last_phase) begin
            if (idx_q == IW'(WIDTH-1)) state_d = STOP_LOW;
            else begin
               state_d = BIT_LOW;
               idx_d   = idx_q + IW'(1);
               shift_d = MSB_FIRST != 0 ? shift_q << 1 : shift_q >> 1;
            end
         end
         STOP_LOW:  if (last_phase) state_d = STOP_HIGH;
         STOP_HIGH: if (last_phase) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      // line levels are registered from the next state so they change exactly on state entry
      scl_d   = !(state_d == BIT_LOW || state_d == STOP_LOW);
      sda_d   = state_d == IDLE     ? 1'b1 :
                state_d == BIT_LOW  ? (MSB_FIRST != 0 ? shift_d[WIDTH-1] : shift_d[0]) :
                state_d == BIT_HIGH ? sda_q : 1'b0;
      busy_d  = state_d != IDLE;
      done_d  = (state_q == STOP_HIGH) && (state_d == IDLE);
      count_d = count_q + LW'(push) - LW'(pop);
      rdy_d   = count_d != LW'(DEPTH);
      ovf_d   = ovf_q | (d_en & full);
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         wr_q    <= push ? wr_q + AW'(1) : wr_q;
         rd_q    <= pop ? rd_q + AW'(1) : rd_q;
         count_q <= count_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         rdy_q   <= rdy_d;
      end
   end

   always_ff @(posedge sclk) begin
      if (push) mem_q[wr_q] <= data;
   end

   assign d_rdy      = rdy_q;
   assign fifo_level = count_q;
   assign scl        = scl_q;
   assign sda        = sda_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overflow   = ovf_q;
endmodule
